// File: rtl/peripherals_io.sv
// Memory-mapped board I/O block: synchronized switch/button/pin inputs,
// LED and output-pin registers, and a multiplexed 4-digit seven-segment
// display with per-digit decimal points and enables.
module peripherals_io #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  input  logic [3:0]  ipin,
  output logic [15:0] led,
  output logic [3:0]  opin,
  output logic [6:0]  hex,
  output logic        hex_dot,
  output logic [3:0]  hex_sel
);

  // Word offsets decoded from A[4:2]
  localparam logic [2:0] REG_SW     = 3'd0;
  localparam logic [2:0] REG_BTN    = 3'd1;
  localparam logic [2:0] REG_IPIN   = 3'd2;
  localparam logic [2:0] REG_LED    = 3'd3;
  localparam logic [2:0] REG_OPIN   = 3'd4;
  localparam logic [2:0] REG_HEXVAL = 3'd5;
  localparam logic [2:0] REG_HEXDOT = 3'd6;
  localparam logic [2:0] REG_HEXEN  = 3'd7;

  logic [2:0] reg_sel;
  assign reg_sel = A[4:2];

  // Byte-lane bits of the address and the high write-data bits carry no meaning here
  logic unused_bits;
  assign unused_bits = &{1'b0, A[1:0], WD[31:16]};

  // ---------------------------------------------------------------------
  // Input synchronizers (two flops each)
  // ---------------------------------------------------------------------
  logic [15:0] sw_meta_reg,   sw_sync_reg;
  logic [4:0]  btn_meta_reg,  btn_sync_reg;
  logic [3:0]  ipin_meta_reg, ipin_sync_reg;

  // Two-stage capture of the asynchronous board inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg   <= '0;
      sw_sync_reg   <= '0;
      btn_meta_reg  <= '0;
      btn_sync_reg  <= '0;
      ipin_meta_reg <= '0;
      ipin_sync_reg <= '0;
    end else begin
      sw_meta_reg   <= sw;
      sw_sync_reg   <= sw_meta_reg;
      btn_meta_reg  <= btn;
      btn_sync_reg  <= btn_meta_reg;
      ipin_meta_reg <= ipin;
      ipin_sync_reg <= ipin_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Writable registers
  // ---------------------------------------------------------------------
  logic [15:0] led_reg;
  logic [3:0]  opin_reg;
  logic [15:0] hexval_reg;
  logic [3:0]  hexdot_reg;
  logic [3:0]  hexen_reg;

  // Register writes; offsets 0x00-0x08 are read-only and fall through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg    <= '0;
      opin_reg   <= '0;
      hexval_reg <= '0;
      hexdot_reg <= '0;
      hexen_reg  <= 4'hF;
    end else if (WE) begin
      case (reg_sel)
        REG_LED:    led_reg    <= WD[15:0];
        REG_OPIN:   opin_reg   <= WD[3:0];
        REG_HEXVAL: hexval_reg <= WD[15:0];
        REG_HEXDOT: hexdot_reg <= WD[3:0];
        REG_HEXEN:  hexen_reg  <= WD[3:0];
        default:    ;
      endcase
    end
  end

  assign led  = led_reg;
  assign opin = opin_reg;

  // Combinational read mux, zero-extended
  always_comb begin
    RD = '0;
    case (reg_sel)
      REG_SW:     RD = {16'b0, sw_sync_reg};
      REG_BTN:    RD = {27'b0, btn_sync_reg};
      REG_IPIN:   RD = {28'b0, ipin_sync_reg};
      REG_LED:    RD = {16'b0, led_reg};
      REG_OPIN:   RD = {28'b0, opin_reg};
      REG_HEXVAL: RD = {16'b0, hexval_reg};
      REG_HEXDOT: RD = {28'b0, hexdot_reg};
      REG_HEXEN:  RD = {28'b0, hexen_reg};
      default:    RD = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------
  logic [REFRESH_BITS-1:0] refresh_reg;
  logic [1:0]              digit;

  assign digit = refresh_reg[REFRESH_BITS-1 -: 2];

  // Free-running refresh counter; its top two bits pick the active digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh_reg <= '0;
    else        refresh_reg <= refresh_reg + 1'b1;
  end

  // Split HEXVAL into its four nibbles
  logic [3:0] digit_nibble [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
      assign digit_nibble[gi] = hexval_reg[4*gi +: 4];
    end
  endgenerate

  // Active-low glyph in {g,f,e,d,c,b,a} order
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  logic [6:0] hex_next;
  logic [3:0] hex_sel_next;
  logic       hex_dot_next;

  // Next display pattern for the currently selected digit
  always_comb begin
    hex_next     = glyph(digit_nibble[digit]);
    hex_dot_next = ~hexdot_reg[digit];
    hex_sel_next = 4'b1111;
    if (hexen_reg[digit]) hex_sel_next = ~(4'b0001 << digit);
  end

  logic [6:0] hex_reg;
  logic [3:0] hex_sel_reg;
  logic       hex_dot_reg;

  // Registered display outputs: one cycle behind the counter/registers, glitch-free pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_reg     <= 7'h40;
      hex_sel_reg <= 4'b1110;
      hex_dot_reg <= 1'b1;
    end else begin
      hex_reg     <= hex_next;
      hex_sel_reg <= hex_sel_next;
      hex_dot_reg <= hex_dot_next;
    end
  end

  assign hex     = hex_reg;
  assign hex_sel = hex_sel_reg;
  assign hex_dot = hex_dot_reg;

endmodule

// File: tb/tb_peripherals_io.sv
// Self-checking bench for peripherals_io with a short refresh counter.
module tb_peripherals_io;

  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [31:0] RD;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [3:0]  ipin = '0;
  logic [15:0] led;
  logic [3:0]  opin;
  logic [6:0]  hex;
  logic        hex_dot;
  logic [3:0]  hex_sel;

  peripherals_io #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .sw(sw), .btn(btn), .ipin(ipin), .led(led), .opin(opin),
    .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Glyph table straight from the display definition
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [15:0] m_led, m_hexval;
  logic [3:0]  m_opin, m_hexdot, m_hexen;
  int          m_edges;
  logic [15:0] m_sw_pend, m_sw_vis;
  logic [4:0]  m_btn_pend, m_btn_vis;
  logic [3:0]  m_ipin_pend, m_ipin_vis;
  logic [3:0]  exp_sel;
  logic [6:0]  exp_hex;
  logic        exp_dot;
  int          exp_digit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_opin = '0; m_hexval = '0; m_hexdot = '0; m_hexen = 4'hF;
    m_edges = 0;
    m_sw_pend = '0; m_sw_vis = '0;
    m_btn_pend = '0; m_btn_vis = '0;
    m_ipin_pend = '0; m_ipin_vis = '0;
    exp_sel = 4'b1110; exp_hex = 7'h40; exp_dot = 1'b1; exp_digit = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    case (a / 4)
      0: return {16'b0, m_sw_vis};
      1: return {27'b0, m_btn_vis};
      2: return {28'b0, m_ipin_vis};
      3: return {16'b0, m_led};
      4: return {28'b0, m_opin};
      5: return {16'b0, m_hexval};
      6: return {28'b0, m_hexdot};
      default: return {28'b0, m_hexen};
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_led"}, {16'b0, led}, {16'b0, m_led});
    chk({tag, "_opin"}, {28'b0, opin}, {28'b0, m_opin});
    chk({tag, "_sel"}, {28'b0, hex_sel}, {28'b0, exp_sel});
    chk({tag, "_hex"}, {25'b0, hex}, {25'b0, exp_hex});
    chk({tag, "_dot"}, {31'b0, hex_dot}, {31'b0, exp_dot});
  endtask

  // One rising edge with the inputs currently applied, then model update and checks
  task automatic step();
    int d;
    logic [3:0] nsel, nib;
    logic [4:0] a_c; logic [31:0] wd_c; logic we_c;
    logic [15:0] sw_c; logic [4:0] btn_c; logic [3:0] ipin_c;
    a_c = A; wd_c = WD; we_c = WE; sw_c = sw; btn_c = btn; ipin_c = ipin;
    d = (m_edges % (1 << RB)) / (1 << (RB - 2));
    nib = m_hexval[4*d +: 4];
    for (int i = 0; i < 4; i++) nsel[i] = !((i == d) && m_hexen[i]);
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_sel = nsel; exp_hex = glyph_tab[nib]; exp_dot = !m_hexdot[d]; exp_digit = d;
      m_edges++;
      m_sw_vis = m_sw_pend; m_sw_pend = sw_c;
      m_btn_vis = m_btn_pend; m_btn_pend = btn_c;
      m_ipin_vis = m_ipin_pend; m_ipin_pend = ipin_c;
      if (we_c) begin
        case (a_c / 4)
          3: m_led = wd_c[15:0];
          4: m_opin = wd_c[3:0];
          5: m_hexval = wd_c[15:0];
          6: m_hexdot = wd_c[3:0];
          7: m_hexen = wd_c[3:0];
          default: ;
        endcase
      end
    end
    $display("edge t=%0t rst_n=%b A=%h WE=%b WD=%h led=%h opin=%h sel=%b hex=%h dot=%b",
             $time, rst_n, a_c, we_c, wd_c, led, opin, hex_sel, hex, hex_dot);
    check_outputs("step");
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input string tag);
    A = a; WE = 1'b0;
    #1;
    chk(tag, RD, model_rd(a));
  endtask

  logic [3:0]  tab_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]  tab_hex [4] = '{7'h0E, 7'h06, 7'h24, 7'h79};
  logic        tab_dot [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("rst_hex_lit", {25'b0, hex}, 32'h40);
    for (int off = 12; off <= 28; off += 4) rd_chk(5'(off), "rst_read");
    chk("rst_hexen_lit", RD, 32'hF);

    // Writes while held in reset are dropped
    wr(5'h0C, 32'hFFFF_FFFF);
    chk("wr_in_reset", {16'b0, led}, 32'h0);
    rst_n = 1'b1;

    // Basic register writes, upper WD bits discarded
    wr(5'h0C, 32'hFFFF_ABCD);
    wr(5'h10, 32'h0000_0005);
    chk("led_lit", {16'b0, led}, 32'hABCD);
    chk("opin_lit", {28'b0, opin}, 32'h5);
    rd_chk(5'h0C, "rd_led");
    chk("rd_led_lit", RD, 32'h0000_ABCD);
    rd_chk(5'h0F, "rd_led_bytelane");

    // Synchronizer latency
    sw = 16'h1234; btn = 5'h11; ipin = 4'h9;
    step();
    rd_chk(5'h00, "sw_1edge"); rd_chk(5'h04, "btn_1edge"); rd_chk(5'h08, "ipin_1edge");
    step();
    rd_chk(5'h00, "sw_2edge"); chk("sw_2edge_lit", RD, 32'h1234);
    rd_chk(5'h04, "btn_2edge"); chk("btn_2edge_lit", RD, 32'h11);
    rd_chk(5'h08, "ipin_2edge"); chk("ipin_2edge_lit", RD, 32'h9);

    // Display scan with known digits and one dot
    wr(5'h14, 32'h0000_12EF);
    wr(5'h18, 32'h0000_0002);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("scan_sel_lit", {28'b0, hex_sel}, {28'b0, tab_sel[exp_digit]});
      chk("scan_hex_lit", {25'b0, hex}, {25'b0, tab_hex[exp_digit]});
      chk("scan_dot_lit", {31'b0, hex_dot}, {31'b0, tab_dot[exp_digit]});
    end

    // Digit enables blank digits 1 and 3; writes to SW are ignored
    wr(5'h1C, 32'h5);
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      if (exp_digit == 1 || exp_digit == 3)
        chk("blank_sel", {28'b0, hex_sel}, 32'hF);
    end
    wr(5'h00, 32'hFFFF_FFFF);
    rd_chk(5'h00, "sw_ro");
    chk("sw_ro_lit", RD, 32'h1234);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      A = 5'($urandom_range(0, 31));
      WD = $urandom;
      WE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        sw = 16'($urandom); btn = 5'($urandom); ipin = 4'($urandom);
      end
      step();
      WE = 1'b0;
      rd_chk(5'($urandom_range(0, 31)), "rand_read");
    end

    // Asynchronous reset mid-frame
    wr(5'h0C, 32'h0000_5A5A);
    wr(5'h14, 32'h0000_8888);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_sel_lit", {28'b0, hex_sel}, 32'hE);
    A = 5'h0C; WD = 32'h1111; WE = 1'b1;
    step();
    WE = 1'b0;
    rd_chk(5'h0C, "rst_hold_read");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rd_chk(5'h1C, "post_rst_hexen");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peripherals_io.md
PERIPHERALS_IO -- requirements
Module: peripherals_io

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 18: width of the display refresh counter; each digit is shown for 2^(REFRESH_BITS-2) cycles.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port A, input, 5 bits: byte address offset within the peripheral window.
REQ-005 SHALL have port WD, input, 32 bits: write data.
REQ-006 SHALL have port WE, input, 1 bit: write enable.
REQ-007 SHALL have port RD, output, 32 bits: read data, combinational.
REQ-008 SHALL have port sw, input, 16 bits: slide switches, asynchronous to clk.
REQ-009 SHALL have port btn, input, 5 bits: push buttons, asynchronous to clk.
REQ-010 SHALL have port ipin, input, 4 bits: general input pins, asynchronous to clk.
REQ-011 SHALL have port led, output, 16 bits: LEDs, active-high.
REQ-012 SHALL have port opin, output, 4 bits: general output pins.
REQ-013 SHALL have port hex, output, 7 bits: seven-segment cathodes, active-low, hex[0]=a … hex[6]=g.
REQ-014 SHALL have port hex_dot, output, 1 bit: decimal point, active-low.
REQ-015 SHALL have port hex_sel, output, 4 bits: digit anodes, active-low; bit 0 is the rightmost digit.

Function
REQ-016 SHALL decode registers by A[4:2] only; A[1:0] are ignored.
REQ-017 SHALL implement this register map (word offset, access, content):
- 0x00 SW, RO: {16'b0, sw_sync}
- 0x04 BTN, RO: {27'b0, btn_sync}
- 0x08 IPIN, RO: {28'b0, ipin_sync}
- 0x0C LED, RW: [15:0]
- 0x10 OPIN, RW: [3:0]
- 0x14 HEXVAL, RW: [15:0], four hex digits; digit i = bits [4i+3:4i]
- 0x18 HEXDOT, RW: [3:0], bit i lights the dot of digit i
- 0x1C HEXEN, RW: [3:0], bit i enables digit i
REQ-018 SHALL drive RD combinationally from A: the register zero-extended to 32 bits; unused upper bits read 0.
REQ-019 SHALL update a RW register at the rising clk edge when WE=1, storing the low-order WD bits of its width; upper WD bits are discarded.
REQ-020 SHALL ignore writes to RO registers.
REQ-021 SHALL pass sw, btn and ipin through a two-flop synchronizer, so a steady input change is visible on RD after the second rising edge.
REQ-022 SHALL drive led and opin directly from their registers, updating in the same edge as the write.
REQ-023 SHALL run a free-running REFRESH_BITS-bit counter that wraps to 0; the counter's top two bits select the active digit d (0..3).
REQ-024 SHALL drive hex_sel low only at bit d, and only when HEXEN[d]=1; otherwise hex_sel = 4'b1111.
REQ-025 SHALL drive hex with the active-low glyph of digit d. Glyphs as hex values of {g..a}:
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
REQ-026 SHALL drive hex_dot = ~HEXDOT[d].
REQ-027 SHALL register display outputs so they are glitch-free; a HEXVAL write is visible no later than 1 cycle after the write edge.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear the following: LED, OPIN, HEXVAL, HEXDOT, the synchronizers and the refresh counter.
REQ-029 SHALL set HEXEN to 4'hF on reset.
REQ-030 SHALL drive these outputs during reset: led=0, opin=0, hex_sel=4'b1110, hex=7'h40, hex_dot=1.
REQ-031 SHALL ignore writes while rst_n=0.
REQ-032 SHALL release reset cleanly when rst_n deasserts mid-operation; register state resumes from reset values at the next edge.

Verification
REQ-033 Reset then read each offset 0x0C–0x1C -> 0,0,0,0,0xF respectively; led=0, opin=0.
REQ-034 Write 0xFFFFABCD to 0x0C, and 0x5 to 0x10 -> led=0xABCD, opin=0x5; read 0x0C returns 0x0000ABCD.
REQ-035 Set sw=0x1234, btn=0x11, ipin=0x9 -> reads of 0x00/0x04/0x08 return 0x1234/0x11/0x9 after 2 edges, still old values after 1 edge.
REQ-036 With REFRESH_BITS=4, write HEXVAL=0x12EF and HEXDOT=0x2, then step time. Required, one digit per period:
- hex_sel=1110, hex=0E, dot=1
- hex_sel=1101, hex=06, dot=0
- hex_sel=1011, hex=24, dot=1
- hex_sel=0111, hex=79, dot=1
REQ-037 Write HEXEN=0x5 -> digits 1 and 3 are blanked (hex_sel=1111 during their slots); write to 0x00 with WE=1 leaves SW read unchanged.
REQ-038 Assert rst_n=0 asynchronously mid-frame after writes -> outputs return to REQ-030 values without a clock edge.
